// File: rtl/gate_lab_pkg.sv
// Shared definitions for the NAND gate lab: default sweep dimensions and the
// stimulus sequencer state encoding.
package gate_lab_pkg;

   localparam int GL_WIDTH = 4;
   localparam int GL_DIV   = 50;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/gate_stim_gen_tick_div.sv
// DIV-cycle prescaler: counts 0..DIV-1 while enabled and emits a one-clock
// tick on the last count; clear forces the count back to zero.
module tick_div #(
   parameter int DIV   = 4,
   parameter int DIV_W = $clog2(DIV) + 1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic tick_o
);

   localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

   logic [DIV_W-1:0] cnt_q;
   logic [DIV_W-1:0] cnt_d;

   assign tick_o = en_i && !clr_i && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/gate_stim_gen.sv
// Stimulus sequencer for the 4-input NAND lab: sweeps every WIDTH-bit pattern
// (binary or Gray order), each held DIV clocks, one-shot or looping.
module gate_stim_gen
   import gate_lab_pkg::*;
#(
   parameter int WIDTH = GL_WIDTH,
   parameter int DIV   = GL_DIV,
   parameter int DIV_W = $clog2(DIV) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             loop,
   input  logic             gray_en,
   output logic [WIDTH-1:0] pattern,
   output logic [WIDTH-1:0] step_idx,
   output logic             pat_valid,
   output logic             busy,
   output logic             done
);

   localparam logic [WIDTH-1:0] STEP_MAX = '1;

   function automatic logic [WIDTH-1:0] map_pat(input logic [WIDTH-1:0] idx,
                                                input logic             gray);
      return gray ? (idx ^ (idx >> 1)) : idx;
   endfunction

   state_e           state_q, state_d;
   logic [WIDTH-1:0] step_q, step_d;
   logic [WIDTH-1:0] pat_q, pat_d;
   logic [WIDTH-1:0] step_nx;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             loop_q, loop_d;
   logic             gray_q, gray_d;
   logic             tick;

   // Prescaler only runs in RUN; any other state parks it at zero so a fresh
   // sweep always gives the first pattern a full DIV clocks.
   tick_div #(
      .DIV   (DIV),
      .DIV_W (DIV_W)
   ) u_tick_div (
      .clk_i  (clk),
      .rst_i  (rst),
      .clr_i  (state_q != ST_RUN),
      .en_i   (state_q == ST_RUN),
      .tick_o (tick)
   );

   assign step_nx = step_q + 1'b1;

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      pat_d   = pat_q;
      valid_d = 1'b0;
      busy_d  = busy_q;
      done_d  = 1'b0;
      loop_d  = loop_q;
      gray_d  = gray_q;
      case (state_q)
         ST_IDLE: begin
            if (start && !stop) begin
               state_d = ST_RUN;
               step_d  = '0;
               pat_d   = map_pat('0, gray_en);
               valid_d = 1'b1;
               busy_d  = 1'b1;
               loop_d  = loop;
               gray_d  = gray_en;
            end
         end
         ST_RUN: begin
            if (stop) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end else if (tick) begin
               if ((step_q == STEP_MAX) && !loop_q) begin
                  state_d = ST_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  // Index wraps modulo 2^WIDTH when looping.
                  step_d  = step_nx;
                  pat_d   = map_pat(step_nx, gray_q);
                  valid_d = 1'b1;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         step_q  <= '0;
         pat_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         loop_q  <= 1'b0;
         gray_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         pat_q   <= pat_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         loop_q  <= loop_d;
         gray_q  <= gray_d;
      end
   end

   assign pattern   = pat_q;
   assign step_idx  = step_q;
   assign pat_valid = valid_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_gate_stim_gen.sv
// Directed bench for gate_stim_gen: three instances (DIV=4, 2, 1) sharing
// clock, reset, stop, loop and gray_en, each with its own start.
module tb_gate_stim_gen;

   logic       clk;
   logic       rst;
   logic       stop;
   logic       loop;
   logic       gray_en;
   logic       start4, start2, start1;
   logic [3:0] pat4, step4, pat2, step2, pat1, step1;
   logic       v4, b4, d4, v2, b2, d2, v1, b1, d1;

   int n_checks;
   int n_fail;
   int sel;

   logic [3:0] m_pat, m_step;
   logic       m_valid, m_busy, m_done;

   logic [3:0] gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

   gate_stim_gen #(.WIDTH(4), .DIV(4)) u4 (
      .clk(clk), .rst(rst), .start(start4), .stop(stop), .loop(loop), .gray_en(gray_en),
      .pattern(pat4), .step_idx(step4), .pat_valid(v4), .busy(b4), .done(d4));

   gate_stim_gen #(.WIDTH(4), .DIV(2)) u2 (
      .clk(clk), .rst(rst), .start(start2), .stop(stop), .loop(loop), .gray_en(gray_en),
      .pattern(pat2), .step_idx(step2), .pat_valid(v2), .busy(b2), .done(d2));

   gate_stim_gen #(.WIDTH(4), .DIV(1)) u1 (
      .clk(clk), .rst(rst), .start(start1), .stop(stop), .loop(loop), .gray_en(gray_en),
      .pattern(pat1), .step_idx(step1), .pat_valid(v1), .busy(b1), .done(d1));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always_comb begin
      m_pat = pat4; m_step = step4; m_valid = v4; m_busy = b4; m_done = d4;
      case (sel)
         2: begin m_pat = pat2; m_step = step2; m_valid = v2; m_busy = b2; m_done = d2; end
         1: begin m_pat = pat1; m_step = step1; m_valid = v1; m_busy = b1; m_done = d1; end
         default: ;
      endcase
   end

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   // Pulses the selected start for one edge; returns one tick after the
   // entry edge, i.e. at sweep cycle 0.
   task automatic pulse_start(input int which);
      sel = which;
      next_cyc();
      if (which == 4) start4 = 1'b1;
      if (which == 2) start2 = 1'b1;
      if (which == 1) start1 = 1'b1;
      next_cyc();
      start4 = 1'b0; start2 = 1'b0; start1 = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({pat4, step4, v4, b4, d4} !== 11'b0) begin
         n_fail++;
         $display("FAIL reset_async: got %b required 0", {pat4, step4, v4, b4, d4});
      end
      next_cyc();
      n_checks++;
      if ({pat2, step2, v2, b2, d2, pat1, step1, v1, b1, d1} !== 22'b0) begin
         n_fail++;
         $display("FAIL reset_held: got %b required 0", {pat2, step2, v2, b2, d2, pat1, step1, v1, b1, d1});
      end
      rst = 1'b0;
      next_cyc();
   endtask

   task automatic test_binary();
      int vcount = 0;
      loop = 1'b0; gray_en = 1'b0;
      pulse_start(4);
      for (int c = 0; c < 64; c++) begin
         n_checks++;
         if ({m_pat, m_step, m_valid, m_busy, m_done} !==
             {4'(c / 4), 4'(c / 4), (c % 4) == 0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL binary c=%0d: got %b required %b", c,
                     {m_pat, m_step, m_valid, m_busy, m_done},
                     {4'(c / 4), 4'(c / 4), (c % 4) == 0, 1'b1, 1'b0});
         end
         if (m_valid) vcount++;
         next_cyc();
      end
      n_checks++;
      if ({m_pat, m_step, m_valid, m_busy, m_done} !== {4'hF, 4'hF, 1'b0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL binary_done: got %b required %b",
                  {m_pat, m_step, m_valid, m_busy, m_done}, {4'hF, 4'hF, 3'b001});
      end
      n_checks++;
      if (vcount != 16) begin
         n_fail++;
         $display("FAIL binary_valid_count: got %0d required 16", vcount);
      end
      next_cyc();
      n_checks++;
      if ({m_pat, m_valid, m_busy, m_done} !== {4'hF, 3'b000}) begin
         n_fail++;
         $display("FAIL binary_done_pulse: got %b required %b",
                  {m_pat, m_valid, m_busy, m_done}, {4'hF, 3'b000});
      end
   endtask

   task automatic test_gray();
      loop = 1'b0; gray_en = 1'b1;
      pulse_start(4);
      gray_en = 1'b0;
      for (int c = 0; c < 64; c++) begin
         n_checks++;
         if ({m_pat, m_step, m_valid, m_busy, m_done} !==
             {gray_tab[c / 4], 4'(c / 4), (c % 4) == 0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL gray c=%0d: got %b required %b", c,
                     {m_pat, m_step, m_valid, m_busy, m_done},
                     {gray_tab[c / 4], 4'(c / 4), (c % 4) == 0, 1'b1, 1'b0});
         end
         next_cyc();
      end
      n_checks++;
      if ({m_pat, m_step, m_busy, m_done} !== {4'h8, 4'hF, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL gray_done: got %b required %b",
                  {m_pat, m_step, m_busy, m_done}, {4'h8, 4'hF, 2'b01});
      end
      next_cyc();
   endtask

   task automatic test_loop();
      loop = 1'b1; gray_en = 1'b0;
      pulse_start(2);
      loop = 1'b0;
      for (int c = 0; c < 40; c++) begin
         n_checks++;
         if ({m_pat, m_step, m_valid, m_busy, m_done} !==
             {4'((c / 2) % 16), 4'((c / 2) % 16), (c % 2) == 0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL loop c=%0d: got %b required %b", c,
                     {m_pat, m_step, m_valid, m_busy, m_done},
                     {4'((c / 2) % 16), 4'((c / 2) % 16), (c % 2) == 0, 1'b1, 1'b0});
         end
         if (c < 39) next_cyc();
      end
      stop = 1'b1;
      next_cyc();
      stop = 1'b0;
      n_checks++;
      if ({m_valid, m_busy, m_done} !== 3'b000) begin
         n_fail++;
         $display("FAIL loop_stop: got %b required 000", {m_valid, m_busy, m_done});
      end
      next_cyc();
   endtask

   task automatic test_abort();
      loop = 1'b0; gray_en = 1'b0;
      pulse_start(4);
      for (int c = 0; c < 21; c++) next_cyc();
      stop = 1'b1;
      next_cyc();
      stop = 1'b0;
      n_checks++;
      if ({m_pat, m_step, m_valid, m_busy, m_done} !== {4'h5, 4'h5, 3'b000}) begin
         n_fail++;
         $display("FAIL abort: got %b required %b",
                  {m_pat, m_step, m_valid, m_busy, m_done}, {4'h5, 4'h5, 3'b000});
      end
      for (int c = 0; c < 70; c++) begin
         if (m_done || m_valid || m_busy || (m_pat !== 4'h5)) begin
            n_checks++;
            n_fail++;
            $display("FAIL abort_hold c=%0d: got %b required %b", c,
                     {m_pat, m_valid, m_busy, m_done}, {4'h5, 3'b000});
         end
         next_cyc();
      end
      n_checks++;
      if ({m_pat, m_busy, m_done} !== {4'h5, 2'b00}) begin
         n_fail++;
         $display("FAIL abort_frozen: got %b required %b", {m_pat, m_busy, m_done}, {4'h5, 2'b00});
      end
      pulse_start(4);
      n_checks++;
      if ({m_pat, m_step, m_valid, m_busy} !== {4'h0, 4'h0, 2'b11}) begin
         n_fail++;
         $display("FAIL abort_restart: got %b required %b",
                  {m_pat, m_step, m_valid, m_busy}, {8'h00, 2'b11});
      end
   endtask

   task automatic test_reset_mid();
      for (int c = 0; c < 36; c++) next_cyc();
      n_checks++;
      if ({m_step, m_busy} !== {4'h9, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_mid_pre: got %b required %b", {m_step, m_busy}, {4'h9, 1'b1});
      end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({m_pat, m_step, m_valid, m_busy, m_done} !== 11'b0) begin
         n_fail++;
         $display("FAIL reset_mid: got %b required 0", {m_pat, m_step, m_valid, m_busy, m_done});
      end
      #1 rst = 1'b0;
      next_cyc();
      n_checks++;
      if ({m_pat, m_busy} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_mid_idle: got %b required 0", {m_pat, m_busy});
      end
   endtask

   task automatic test_ignored();
      sel = 4;
      start4 = 1'b1; stop = 1'b1;
      next_cyc();
      start4 = 1'b0; stop = 1'b0;
      next_cyc();
      n_checks++;
      if ({m_valid, m_busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL start_stop_idle: got %b required 00", {m_valid, m_busy});
      end
      pulse_start(4);
      next_cyc();
      start4 = 1'b1;
      next_cyc();
      start4 = 1'b0;
      next_cyc();
      n_checks++;
      if ({m_pat, m_step, m_valid, m_busy} !== {4'h0, 4'h0, 2'b01}) begin
         n_fail++;
         $display("FAIL start_in_run_c3: got %b required %b",
                  {m_pat, m_step, m_valid, m_busy}, {8'h00, 2'b01});
      end
      next_cyc();
      n_checks++;
      if ({m_pat, m_step, m_valid, m_busy} !== {4'h1, 4'h1, 2'b11}) begin
         n_fail++;
         $display("FAIL start_in_run_c4: got %b required %b",
                  {m_pat, m_step, m_valid, m_busy}, {8'h11, 2'b11});
      end
      stop = 1'b1;
      next_cyc();
      stop = 1'b0;
      next_cyc();
   endtask

   task automatic test_div1();
      loop = 1'b0; gray_en = 1'b0;
      pulse_start(1);
      for (int c = 0; c < 16; c++) begin
         n_checks++;
         if ({m_pat, m_step, m_valid, m_busy, m_done} !== {4'(c), 4'(c), 3'b110}) begin
            n_fail++;
            $display("FAIL div1 c=%0d: got %b required %b", c,
                     {m_pat, m_step, m_valid, m_busy, m_done}, {4'(c), 4'(c), 3'b110});
         end
         next_cyc();
      end
      n_checks++;
      if ({m_pat, m_valid, m_busy, m_done} !== {4'hF, 3'b001}) begin
         n_fail++;
         $display("FAIL div1_done: got %b required %b",
                  {m_pat, m_valid, m_busy, m_done}, {4'hF, 3'b001});
      end
      next_cyc();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      sel      = 4;
      stop     = 1'b0;
      loop     = 1'b0;
      gray_en  = 1'b0;
      start4   = 1'b0;
      start2   = 1'b0;
      start1   = 1'b0;
      test_reset();
      test_binary();
      test_gray();
      test_loop();
      test_abort();
      test_reset_mid();
      test_ignored();
      test_div1();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
